serial_mag_comp_ctrl: RTL and testbench



---
 rtl/serial_mag_comp_ctrl.sv | 154 +++++++++++++++
 tb/tb_serial_mag_comp_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comp_ctrl.sv
// serial_mag_comp_ctrl: serial unsigned magnitude comparator, 2 bits per cycle, MSB digit first.
// One 2-bit cascaded slice is reused every cycle; its eq/gt outputs feed back as the
// next digit's eq_prev/gt_prev.
// Optional build macro SERIAL_COMP_EARLY_EXIT_EN: finish as soon as a digit differs.
module serial_mag_comp_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int unsigned DIGITS = WIDTH / 2;
    localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   sa;
    logic [WIDTH-1:0]   sb;
    logic [WIDTH-1:0]   sa_next;
    logic [WIDTH-1:0]   sb_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               eq_acc;
    logic               gt_acc;
    logic               eq_acc_d;
    logic               gt_acc_d;
    logic               eq_acc_next;
    logic               gt_acc_next;
    logic [1:0]         dig_a;
    logic [1:0]         dig_b;
    logic               dig_eq;
    logic               dig_gt;
    logic               accept;
    logic               run_last;
    logic               busy_next;
    logic               done_next;
    logic               eq_next;
    logic               gt_next;
    logic               lt_next;

    // 2-bit cascaded comparator slice on the current MSB digit
    always_comb begin
        dig_a       = sa[WIDTH-1 -: 2];
        dig_b       = sb[WIDTH-1 -: 2];
        dig_eq      = (dig_a == dig_b);
        dig_gt      = (dig_a > dig_b);
        eq_acc_next = eq_acc & dig_eq;
        gt_acc_next = gt_acc | (eq_acc & dig_gt);
    end

    // Last RUN cycle: all digits consumed (or, with early exit, result already decided)
`ifdef SERIAL_COMP_EARLY_EXIT_EN
    assign run_last = (cnt == '0) || !eq_acc_next;
`else
    assign run_last = (cnt == '0);
`endif

    // New operands are taken only from IDLE or DONE
    assign accept = start && ((state == S_IDLE) || (state == S_DONE));

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (run_last) state_next = S_DONE;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        sa_next   = sa;
        sb_next   = sb;
        cnt_next  = cnt;
        eq_acc_d  = eq_acc;
        gt_acc_d  = gt_acc;
        eq_next   = eq;
        gt_next   = gt;
        lt_next   = lt;
        busy_next = (state_next == S_RUN);
        done_next = (state_next == S_DONE);
        if (accept) begin
            sa_next  = a;
            sb_next  = b;
            eq_acc_d = 1'b1;
            gt_acc_d = 1'b0;
            cnt_next = CNT_W'(DIGITS - 1);
        end else if (state == S_RUN) begin
            sa_next  = {sa[WIDTH-3:0], 2'b00};
            sb_next  = {sb[WIDTH-3:0], 2'b00};
            eq_acc_d = eq_acc_next;
            gt_acc_d = gt_acc_next;
            cnt_next = run_last ? '0 : (cnt - CNT_W'(1));
            if (run_last) begin
                eq_next = eq_acc_next;
                gt_next = gt_acc_next;
                lt_next = ~eq_acc_next & ~gt_acc_next;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sa     <= '0;
            sb     <= '0;
            cnt    <= '0;
            eq_acc <= 1'b0;
            gt_acc <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            eq     <= 1'b0;
            gt     <= 1'b0;
            lt     <= 1'b0;
        end else begin
            sa     <= sa_next;
            sb     <= sb_next;
            cnt    <= cnt_next;
            eq_acc <= eq_acc_d;
            gt_acc <= gt_acc_d;
            busy   <= busy_next;
            done   <= done_next;
            eq     <= eq_next;
            gt     <= gt_next;
            lt     <= lt_next;
        end
    end

endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// Testbench for serial_mag_comp_ctrl: an 8-bit and a 32-bit instance, directed and
// random compares checked against an arithmetic reference model.
module tb_serial_mag_comp_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel = 1'b0;
    logic        start_d = 1'b0;
    logic [31:0] a_d = '0;
    logic [31:0] b_d = '0;

    logic        start8, start32;
    logic [7:0]  a8, b8;
    logic [31:0] a32, b32;
    logic        busy8, done8, eq8, gt8, lt8;
    logic        busy32, done32, eq32, gt32, lt32;
    logic        busy_s, done_s;
    logic [2:0]  res_s;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [2:0]  prev_res [2];

    always #5 clock = ~clock;

    assign start8  = start_d & ~sel;
    assign start32 = start_d & sel;
    assign a8      = a_d[7:0];
    assign b8      = b_d[7:0];
    assign a32     = a_d;
    assign b32     = b_d;
    assign busy_s  = sel ? busy32 : busy8;
    assign done_s  = sel ? done32 : done8;
    assign res_s   = sel ? {eq32, gt32, lt32} : {eq8, gt8, lt8};

    serial_mag_comp_ctrl #(.WIDTH(8)) u_dut8 (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start8),
        .a       (a8),
        .b       (b8),
        .busy    (busy8),
        .done    (done8),
        .eq      (eq8),
        .gt      (gt8),
        .lt      (lt8)
    );

    serial_mag_comp_ctrl #(.WIDTH(32)) u_dut32 (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start32),
        .a       (a32),
        .b       (b32),
        .busy    (busy32),
        .done    (done32),
        .eq      (eq32),
        .gt      (gt32),
        .lt      (lt32)
    );

    // Expected number of RUN cycles for a compare of d digits
    function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y, input int d);
`ifdef SERIAL_COMP_EARLY_EXIT_EN
        for (int i = 0; i < d; i++) begin
            if (((x >> (2 * (d - 1 - i))) & 32'd3) != ((y >> (2 * (d - 1 - i))) & 32'd3))
                return i + 1;
        end
        return d;
`else
        if (x == y) return d;
        return d;
`endif
    endfunction

    // One compare on the selected instance; optionally pulses an ignored start mid-run
    // and optionally chains straight into the next request from the DONE cycle.
    task automatic run_cmp(input string name, input logic [31:0] av, input logic [31:0] bv,
                           input bit started, input int inj_at, input bit chain,
                           input logic [31:0] nav, input logic [31:0] nbv);
        int          d;
        int          lat;
        int          n;
        logic [31:0] wa;
        logic [31:0] wb;
        logic [2:0]  exp_res;
        d       = sel ? 16 : 4;
        wa      = sel ? av : (av & 32'hFF);
        wb      = sel ? bv : (bv & 32'hFF);
        exp_res = {wa == wb, wa > wb, wa < wb};
        lat     = exp_lat(wa, wb, d);
        if (!started) begin
            @(negedge clock);
            start_d = 1'b1;
            a_d     = av;
            b_d     = bv;
        end
        @(negedge clock);
        start_d = 1'b0;
        n = 0;
        while (done_s !== 1'b1 && n < 64) begin
            n_cmp++;
            if (busy_s !== 1'b1) begin
                n_bad++;
                $display("FAIL %s busy_run cyc%0d: got %b want 1", name, n, busy_s);
            end
            n_cmp++;
            if (res_s !== prev_res[sel]) begin
                n_bad++;
                $display("FAIL %s hold_run cyc%0d: got %b want %b", name, n, res_s, prev_res[sel]);
            end
            n++;
            start_d = (n == inj_at);
            a_d     = start_d ? 32'hFFFF_FFFF : $urandom;
            b_d     = start_d ? 32'h0 : $urandom;
            @(negedge clock);
        end
        n_cmp++;
        if (done_s !== 1'b1) begin
            n_bad++;
            $display("FAIL %s done_timeout: got %b want 1", name, done_s);
        end
        n_cmp++;
        if (n != lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", name, n, lat);
        end
        n_cmp++;
        if (busy_s !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy_done: got %b want 0", name, busy_s);
        end
        n_cmp++;
        if (res_s !== exp_res) begin
            n_bad++;
            $display("FAIL %s result eq/gt/lt: got %b want %b", name, res_s, exp_res);
        end
        prev_res[sel] = exp_res;
        if (chain) begin
            start_d = 1'b1;
            a_d     = nav;
            b_d     = nbv;
        end else begin
            start_d = 1'b0;
            repeat (2) begin
                @(negedge clock);
                n_cmp++;
                if ({busy_s, done_s} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL %s idle busy/done: got %b want 00", name, {busy_s, done_s});
                end
                n_cmp++;
                if (res_s !== exp_res) begin
                    n_bad++;
                    $display("FAIL %s idle_hold: got %b want %b", name, res_s, exp_res);
                end
                a_d = $urandom;
                b_d = $urandom;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start_d = 1'b0;
        sel     = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({busy8, done8, eq8, gt8, lt8} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset8: got %b want 00000", {busy8, done8, eq8, gt8, lt8});
        end
        n_cmp++;
        if ({busy32, done32, eq32, gt32, lt32} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset32: got %b want 00000", {busy32, done32, eq32, gt32, lt32});
        end
        reset_n = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({busy8, done8, eq8, gt8, lt8} !== 5'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset8: got %b want 00000", {busy8, done8, eq8, gt8, lt8});
        end
        prev_res[0] = 3'b000;
        prev_res[1] = 3'b000;
    endtask

    task automatic test_basic;
        sel = 1'b0;
        run_cmp("eq_5a",   32'h5A, 32'h5A, 1'b0, -1, 1'b0, 32'h0, 32'h0);
        run_cmp("gt_80_7f", 32'h80, 32'h7F, 1'b0, -1, 1'b0, 32'h0, 32'h0);
        run_cmp("lt_02_03", 32'h02, 32'h03, 1'b0, -1, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_ignored_start;
        sel = 1'b0;
        run_cmp("ignored_start", 32'h10, 32'h20, 1'b0, 2, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_back_to_back;
        sel = 1'b1;
        run_cmp("b2b_first",  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, -1, 1'b1, 32'h0, 32'h1);
        run_cmp("b2b_second", 32'h0, 32'h1, 1'b1, -1, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_async_reset;
        sel = 1'b0;
        @(negedge clock);
        start_d = 1'b1;
        a_d     = 32'h5A;
        b_d     = 32'h5A;
        @(negedge clock);
        start_d = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy8, done8, eq8, gt8, lt8} !== 5'b0) begin
            n_bad++;
            $display("FAIL async_reset8: got %b want 00000", {busy8, done8, eq8, gt8, lt8});
        end
        n_cmp++;
        if ({busy32, done32, eq32, gt32, lt32} !== 5'b0) begin
            n_bad++;
            $display("FAIL async_reset32: got %b want 00000", {busy32, done32, eq32, gt32, lt32});
        end
        prev_res[0] = 3'b000;
        prev_res[1] = 3'b000;
        @(negedge clock);
        reset_n = 1'b1;
        run_cmp("post_reset_33", 32'h33, 32'h33, 1'b0, -1, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_random;
        bit          started;
        bit          chain;
        int          inj;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] nav;
        logic [31:0] nbv;
        started = 1'b0;
        av = $urandom;
        bv = $urandom;
        for (int i = 0; i < 30; i++) begin
            if (!started) sel = 1'($urandom_range(0, 1));
            chain = (i < 29) && ($urandom_range(0, 2) == 0);
            inj   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 16)) : -1;
            nav   = $urandom;
            case ($urandom_range(0, 2))
                0:       nbv = $urandom;
                1:       nbv = nav;
                default: nbv = nav ^ (32'($urandom_range(1, 3)) << (2 * $urandom_range(0, 15)));
            endcase
            run_cmp($sformatf("rand%0d", i), av, bv, started, inj, chain, nav, nbv);
            started = chain;
            av = nav;
            bv = nbv;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_ignored_start();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
